// File: rtl/stdp_pkg.sv
// Shared defaults, types and the update-kind encoding for the STDP synapse bank.
package stdp_pkg;
  localparam int N_SYN_D        = 4;
  localparam int W_WIDTH_D      = 8;
  localparam int CNT_WIDTH_D    = 4;
  localparam int WINDOW_D       = 10;
  localparam int INIT_WEIGHT_D  = 100;
  localparam int POS_DELTA_D    = 10;
  localparam int NEG_DELTA_D    = 5;
  localparam int W_MIN_D        = 0;
  localparam int W_MAX_D        = 255;
  localparam int DECAY_PERIOD_D = 64;

  typedef logic [CNT_WIDTH_D-1:0] trace_t;
  typedef logic [W_WIDTH_D-1:0]   weight_t;

  typedef enum logic [2:0] {NONE, LTP, LTD, WRITE, DECAY} upd_kind_e;
endpackage

// File: rtl/stdp_trace.sv
// STDP timing trace: reloads WINDOW on a spike, otherwise counts down and holds at 0.
module stdp_trace
  import stdp_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_D,
  parameter int WINDOW    = WINDOW_D
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spike,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 near
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (spike)
      count <= CNT_WIDTH'(WINDOW);
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign near = (count > CNT_WIDTH'(WINDOW / 2));
endmodule

// File: rtl/stdp_synapse_array.sv
// N_SYN plastic synapses onto one post neuron: per-channel STDP, host access, weighted-sum PSC.
// Optional weight decay toward INIT_WEIGHT is enabled with the STDP_DECAY_EN macro.
module stdp_synapse_array
  import stdp_pkg::*;
#(
  parameter int N_SYN        = N_SYN_D,
  parameter int W_WIDTH      = W_WIDTH_D,
  parameter int CNT_WIDTH    = CNT_WIDTH_D,
  parameter int WINDOW       = WINDOW_D,
  parameter int INIT_WEIGHT  = INIT_WEIGHT_D,
  parameter int POS_DELTA    = POS_DELTA_D,
  parameter int NEG_DELTA    = NEG_DELTA_D,
  parameter int W_MIN        = W_MIN_D,
  parameter int W_MAX        = W_MAX_D,
  parameter int DECAY_PERIOD = DECAY_PERIOD_D
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [N_SYN-1:0]                    pre_spike,
  input  logic                                post_spike,
  input  logic                                learn_en,
  input  logic                                wr_en,
  input  logic [$clog2(N_SYN)-1:0]            wr_addr,
  input  logic [W_WIDTH-1:0]                  wr_data,
  input  logic [$clog2(N_SYN)-1:0]            rd_addr,
  output logic [W_WIDTH-1:0]                  rd_data,
  output logic [N_SYN*W_WIDTH-1:0]            weights,
  output logic [W_WIDTH+$clog2(N_SYN)-1:0]    psc,
  output logic [15:0]                         update_cnt
);
  localparam int AW = $clog2(N_SYN);
  localparam int SW = W_WIDTH + AW;
  localparam int XW = W_WIDTH + 1;
  localparam int PW = $clog2(N_SYN + 1);

  localparam logic [XW-1:0]      MIN_X    = XW'(W_MIN);
  localparam logic [XW-1:0]      MAX_X    = XW'(W_MAX);
  localparam logic [XW-1:0]      POS_FULL = XW'(POS_DELTA);
  localparam logic [XW-1:0]      POS_HALF = XW'(POS_DELTA >> 1);
  localparam logic [XW-1:0]      NEG_FULL = XW'(NEG_DELTA);
  localparam logic [XW-1:0]      NEG_HALF = XW'(NEG_DELTA >> 1);
  localparam logic [W_WIDTH-1:0] INIT_W   = W_WIDTH'(INIT_WEIGHT);

  logic [W_WIDTH-1:0]   weight [N_SYN];
  logic [CNT_WIDTH-1:0] pre_cnt [N_SYN];
  logic [N_SYN-1:0]     pre_near;
  logic [CNT_WIDTH-1:0] post_cnt;
  logic                 post_near;
  logic [N_SYN-1:0]     stdp_chg;
  logic [W_WIDTH-1:0]   wr_clamped;

  stdp_trace #(.CNT_WIDTH(CNT_WIDTH), .WINDOW(WINDOW)) u_post_trace (
    .clk(clk), .reset_n(reset_n), .spike(post_spike), .count(post_cnt), .near(post_near)
  );

`ifdef STDP_DECAY_EN
  localparam int PRW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  logic [PRW-1:0] presc;
  logic           decay_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      presc <= '0;
    else if (presc == PRW'(DECAY_PERIOD - 1))
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end

  assign decay_tick = learn_en && (presc == PRW'(DECAY_PERIOD - 1));
`endif

  always_comb begin
    wr_clamped = wr_data;
    if ({1'b0, wr_data} < MIN_X)
      wr_clamped = W_WIDTH'(W_MIN);
    else if ({1'b0, wr_data} > MAX_X)
      wr_clamped = W_WIDTH'(W_MAX);
  end

  for (genvar gi = 0; gi < N_SYN; gi++) begin : g_ch
    logic               ltp, ltd, wr_hit;
    logic [XW-1:0]      w_x, step, up_x, dn_x;
    logic [W_WIDTH-1:0] w_next;
    upd_kind_e          kind;

    stdp_trace #(.CNT_WIDTH(CNT_WIDTH), .WINDOW(WINDOW)) u_pre_trace (
      .clk(clk), .reset_n(reset_n), .spike(pre_spike[gi]),
      .count(pre_cnt[gi]), .near(pre_near[gi])
    );

    assign w_x    = {1'b0, weight[gi]};
    assign wr_hit = wr_en && (wr_addr == AW'(gi));
    assign ltp    = learn_en && post_spike && (pre_cnt[gi] != '0) && !pre_spike[gi];
    assign ltd    = learn_en && pre_spike[gi] && (post_cnt != '0) && !post_spike;

    // One extra bit of headroom so the add/subtract can be clamped rather than wrap.
    always_comb begin
      step = '0;
      if (ltp)
        step = pre_near[gi] ? POS_FULL : POS_HALF;
      else if (ltd)
        step = post_near ? NEG_FULL : NEG_HALF;

      up_x = w_x + step;
      if (up_x > MAX_X)
        up_x = MAX_X;
      dn_x = (step > w_x) ? MIN_X : (w_x - step);
      if (dn_x < MIN_X)
        dn_x = MIN_X;

      kind   = NONE;
      w_next = weight[gi];
      if (wr_hit) begin
        kind   = WRITE;
        w_next = wr_clamped;
      end else if (ltp) begin
        kind   = LTP;
        w_next = up_x[W_WIDTH-1:0];
      end else if (ltd) begin
        kind   = LTD;
        w_next = dn_x[W_WIDTH-1:0];
      end
`ifdef STDP_DECAY_EN
      else if (decay_tick && (weight[gi] != INIT_W)) begin
        kind   = DECAY;
        w_next = (weight[gi] > INIT_W) ? (weight[gi] - 1'b1) : (weight[gi] + 1'b1);
      end
`endif
    end

    assign stdp_chg[gi] = ((kind == LTP) || (kind == LTD)) && (w_next != weight[gi]);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        weight[gi] <= INIT_W;
      else if (kind != NONE)
        weight[gi] <= w_next;
    end

    assign weights[gi*W_WIDTH +: W_WIDTH] = weight[gi];
  end

  logic [SW-1:0]      psc_sum;
  logic [PW-1:0]      chg_pop;
  logic [16:0]        cnt_sum;
  logic [W_WIDTH-1:0] rd_sel;

  // Out-of-range rd_addr matches no channel and therefore reads 0.
  always_comb begin
    psc_sum = '0;
    chg_pop = '0;
    rd_sel  = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (pre_spike[i])
        psc_sum = psc_sum + SW'(weight[i]);
      chg_pop = chg_pop + PW'(stdp_chg[i]);
      if (rd_addr == AW'(i))
        rd_sel = weight[i];
    end
    cnt_sum = {1'b0, update_cnt} + 17'(chg_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc        <= '0;
      rd_data    <= INIT_W;
      update_cnt <= '0;
    end else begin
      psc        <= psc_sum;
      rd_data    <= rd_sel;
      update_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed bench for stdp_synapse_array with a queue of expected values popped at each check.
module tb_stdp_synapse_array;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  pre_spike;
  logic        post_spike;
  logic        learn_en;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [31:0] weights;
  logic [9:0]  psc;
  logic [15:0] update_cnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  stdp_synapse_array dut (
    .clk(clk), .reset_n(reset_n), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .weights(weights), .psc(psc),
    .update_cnt(update_cnt)
  );

  function automatic logic [31:0] w(input int ch);
    return 32'(weights[ch*8 +: 8]);
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_underflow observed=%0d", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse(input logic [3:0] pre, input logic post);
    pre_spike  = pre;
    post_spike = post;
    cyc();
    pre_spike  = '0;
    post_spike = 1'b0;
  endtask

  task automatic host_write(input logic [1:0] ch, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = ch;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; pre_spike = '0; post_spike = 1'b0; learn_en = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    idle(3);
    reset_n = 1'b1;
    cyc();

    push("reset_w0", 100);   check(w(0));
    push("reset_w3", 100);   check(w(3));
    push("reset_rd", 100);   check(32'(rd_data));
    push("reset_psc", 0);    check(32'(psc));
    push("reset_cnt", 0);    check(32'(update_cnt));

    // LTP, full step: pre then post one cycle later
    pulse(4'b0001, 1'b0); pulse(4'b0000, 1'b1);
    push("ltp_full_w0", 110); check(w(0));
    push("ltp_full_cnt", 1);  check(32'(update_cnt));
    idle(12);

    // LTP, half step: post at cycle 7
    pulse(4'b0001, 1'b0); idle(6); pulse(4'b0000, 1'b1);
    push("ltp_half_w0", 115); check(w(0));
    push("ltp_half_cnt", 2);  check(32'(update_cnt));
    idle(12);

    // Outside the window: post at cycle 11
    pulse(4'b0001, 1'b0); idle(10); pulse(4'b0000, 1'b1);
    push("ltp_none_w0", 115); check(w(0));
    push("ltp_none_cnt", 2);  check(32'(update_cnt));
    idle(12);

    // LTD: post at 0, pre on channel 2 at 3
    pulse(4'b0000, 1'b1); idle(2); pulse(4'b0100, 1'b0);
    push("ltd_w2", 95);  check(w(2));
    push("ltd_cnt", 3);  check(32'(update_cnt));
    idle(12);

    // Upper clamp, then a saturated no-op that must not count
    host_write(2'd1, 8'd250);
    pulse(4'b0010, 1'b0); pulse(4'b0000, 1'b1);
    push("clamp_hi_w1", 255); check(w(1));
    push("clamp_hi_cnt", 4);  check(32'(update_cnt));
    idle(12);
    pulse(4'b0010, 1'b0); pulse(4'b0000, 1'b1);
    push("clamp_hi_noop_w1", 255); check(w(1));
    push("clamp_hi_noop_cnt", 4);  check(32'(update_cnt));
    idle(12);

    // Lower clamp
    host_write(2'd1, 8'd3);
    pulse(4'b0000, 1'b1); pulse(4'b0010, 1'b0);
    push("clamp_lo_w1", 0);  check(w(1));
    push("clamp_lo_cnt", 5); check(32'(update_cnt));
    idle(12);

    // Same-cycle pre and post on channel 0
    pulse(4'b0001, 1'b1);
    push("simul_w0", 115); check(w(0));
    push("simul_cnt", 5);  check(32'(update_cnt));
    idle(12);

    // Host write wins over LTP on channel 3
    pulse(4'b1000, 1'b0);
    post_spike = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'd42;
    cyc();
    post_spike = 1'b0; wr_en = 1'b0;
    push("prio_w3", 42);  check(w(3));
    push("prio_w2", 95);  check(w(2));
    push("prio_cnt", 5);  check(32'(update_cnt));
    idle(12);

    // learn_en low: traces run, weights frozen
    learn_en = 1'b0;
    pulse(4'b0001, 1'b0); pulse(4'b0000, 1'b1);
    learn_en = 1'b1;
    push("nolearn_w0", 115); check(w(0));
    idle(12);

    // PSC and readback
    host_write(2'd0, 8'd100);
    host_write(2'd2, 8'd60);
    pulse(4'b0101, 1'b0);
    push("psc_0101", 160); check(32'(psc));
    cyc();
    push("psc_idle", 0);   check(32'(psc));
    rd_addr = 2'd2;
    cyc();
    push("rd_ch2", 60);    check(32'(rd_data));

    // A write at t is visible on rd_data at t+2
    rd_addr = 2'd0; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd77;
    cyc();
    wr_en = 1'b0;
    push("rd_wr_t1", 100); check(32'(rd_data));
    cyc();
    push("rd_wr_t2", 77);  check(32'(rd_data));
    idle(12);

    // Asynchronous reset in the middle of a window
    pulse(4'b0001, 1'b0); idle(2);
    #2 reset_n = 1'b0;
    #1;
    push("rst_w0", 100);  check(w(0));
    push("rst_w3", 100);  check(w(3));
    push("rst_cnt", 0);   check(32'(update_cnt));
    push("rst_rd", 100);  check(32'(rd_data));
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc();
    pulse(4'b0000, 1'b1);
    push("rst_trace_w0", 100); check(w(0));
    push("rst_trace_cnt", 0);  check(32'(update_cnt));
    idle(12);

`ifdef STDP_DECAY_EN
    host_write(2'd0, 8'd110);
    idle(64);
    push("decay_w0", 109); check(w(0));
    push("decay_cnt", 0);  check(32'(update_cnt));
`endif

    if (sb.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stdp_synapse_array.md
Name: stdp_synapse_array

Overview:
Parametrised plastic synapse bank: N_SYN pre-synaptic channels converge on one post-synaptic neuron, each channel with its own weight and STDP timing trace.
- Weight updates are graded (near and far in the window) and saturate at programmable bounds.
- Weights are host-loadable and readable.
- Produces a registered weighted-sum current for the downstream weighted LIF neuron.
- Replaces the single-synapse STDP block between two LIF stages.

Parameters:
N_SYN, 4, number of pre-synaptic channels (2..16)
W_WIDTH, 8, weight width in bits
CNT_WIDTH, 4, timing-trace counter width
WINDOW, 10, trace reload value (1..2^CNT_WIDTH-1)
INIT_WEIGHT, 100, reset weight of every channel
POS_DELTA, 10, full potentiation step
NEG_DELTA, 5, full depression step
W_MIN, 0, lower weight clamp
W_MAX, 255, upper weight clamp (W_MIN <= INIT_WEIGHT <= W_MAX < 2^W_WIDTH)
DECAY_PERIOD, 64, cycles between decay steps (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
pre_spike  in  N_SYN  one pulse per channel, 1 cycle wide
post_spike  in  1  post-neuron spike pulse
learn_en  in  1  1 = STDP (and decay) updates allowed
wr_en  in  1  host weight write strobe
wr_addr  in  clog2(N_SYN)  write channel index
wr_data  in  W_WIDTH  write value (clamped to [W_MIN,W_MAX])
rd_addr  in  clog2(N_SYN)  readback channel index
rd_data  out  W_WIDTH  registered weight of rd_addr
weights  out  N_SYN*W_WIDTH  all weights packed, channel 0 in LSBs
psc  out  W_WIDTH+clog2(N_SYN)  registered sum of weights of channels spiking this cycle
update_cnt  out  16  saturating count of STDP weight changes

Behaviour:
- Reset values:
  - all weights = INIT_WEIGHT.
  - all traces = 0.
  - rd_data = INIT_WEIGHT.
  - psc = 0.
  - update_cnt = 0.
- Traces:
  - pre_cnt[i] reloads WINDOW on pre_spike[i], else decrements toward 0 and holds at 0.
  - post_cnt behaves the same way on post_spike.
- Trace sampling: all decisions in a cycle use the registered trace values from before that cycle's update.
  - Example: pre at cycle 0 is seen by a post at cycle k as WINDOW-(k-1) for k=1..WINDOW, and as 0 thereafter.
- LTP, channel i: post_spike && pre_cnt[i]>0 && !pre_spike[i].
  - Step = POS_DELTA if pre_cnt[i] > WINDOW/2 (integer division), else POS_DELTA>>1.
- LTD, channel i: pre_spike[i] && post_cnt>0 && !post_spike.
  - Step = NEG_DELTA if post_cnt > WINDOW/2, else NEG_DELTA>>1.
- Same-cycle pre_spike[i] and post_spike: no weight change on channel i; both traces reload.
- Arithmetic:
  - Computed at W_WIDTH+1 bits.
  - Result is clamped to [W_MIN,W_MAX] and never wraps.
  - A step of 0 or a clamped no-op is not counted as an update.
- learn_en=0: traces still run; no STDP or decay weight changes.
- Host write: the wr_en write to wr_addr takes priority over learning on that channel in the same cycle; other channels learn normally.
- update_cnt: adds the number of channels whose weight actually changed via STDP this cycle; saturates at 0xFFFF.
- psc:
  - Registered, 1-cycle latency: psc(t+1) = sum of weight[i](t) over channels with pre_spike[i](t).
  - Uses pre-update weights.
  - Never overflows, by width.
- rd_data: registered; rd_data(t+1) = weight[rd_addr(t)](t). A write at cycle t is visible at t+2.
- Out-of-range wr_addr (N_SYN not a power of 2): write ignored. Out-of-range rd_addr returns 0.
- Reset mid-operation: everything returns to reset values immediately and asynchronously; no partial update survives.

Optional Feature:
Macro STDP_DECAY_EN.
- Defined:
  - A free-running prescaler counts to DECAY_PERIOD-1 and then wraps.
  - On wrap with learn_en=1, every weight not touched by STDP or a host write that cycle moves 1 toward INIT_WEIGHT.
  - Decay steps are not counted in update_cnt.
  - The prescaler resets to 0.
- Undefined: no prescaler logic; weights change only by STDP or host write.

Decomposition:
- Package stdp_pkg:
  - default-parameter constants.
  - a trace-count typedef sized by CNT_WIDTH.
  - a weight typedef sized by W_WIDTH.
  - an update-kind enum: NONE, LTP, LTD, WRITE, DECAY.
- Sub-module stdp_trace: a single reload/decrement counter with reset_n. It outputs the count and the near-window flag (count > WINDOW/2), and is instantiated N_SYN+1 times.
- The update arbitration and clamp for one channel sit in a generate loop in the top.

Test Plan:
(Defaults, learn_en=1.)
- LTP graded:
  - pre_spike[0] at cycle 0, post at cycle 1 -> w0 100->110.
  - Repeat with post at cycle 7 -> +5.
  - Post at cycle 11 -> no change.
- LTD: post at cycle 0, pre_spike[2] at cycle 3 -> w2 100->95, update_cnt +1.
- Clamp:
  - Host write w1=250, then an LTP pair -> w1=255.
  - Write 3, then an LTD pair -> 0.
  - Neither wraps.
- Simultaneous and priority:
  - pre_spike[0] and post_spike in the same cycle -> w0 unchanged.
  - wr_en to ch3 plus LTP on ch3 in the same cycle -> w3 = wr_data.
- psc and readback: pre_spike=4'b0101 with w0=100, w2=60 -> psc=160 next cycle; rd_addr=2 -> rd_data=60 one cycle later.
- Reset and decay:
  - Assert reset_n low mid-window -> all weights return to 100 and the traces clear.
  - With STDP_DECAY_EN, w0=110 -> 109 after 64 cycles.
